// File: rtl/run_pattern_gen.sv
// Serial run-length pattern generator: emits in_count ones followed by GAP zeros per frame,
// with back-to-back frame acceptance in the last gap cycle and a wrapping frame counter.
module run_pattern_gen #(
    parameter int unsigned CW  = 2,
    parameter int unsigned GAP = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [CW-1:0] in_count,
    output logic          in_ready,
    output logic          data,
    output logic          busy,
    output logic          done,
    output logic [7:0]    frames_sent
);

    typedef enum logic [1:0] {StIdle, StRun, StGap} state_e;

    localparam logic [3:0] GapInit = 4'(GAP);

    state_e        state;
    logic [CW-1:0] run_cnt;
    logic [3:0]    gap_cnt;
    logic          take;
    logic          run_last;

    assign take     = in_ready && in_valid;
    assign run_last = (state == StRun) && (run_cnt == CW'(1));

    // Counters hold the cycles remaining including the current one; outputs are computed
    // for the state being entered so every output comes straight from a flop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= StIdle;
            run_cnt     <= '0;
            gap_cnt     <= '0;
            in_ready    <= 1'b0;
            data        <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            frames_sent <= '0;
        end else begin
            done     <= 1'b0;
            in_ready <= 1'b0;
            data     <= 1'b0;
            busy     <= 1'b1;
            if (take && (in_count != '0)) begin
                state   <= StRun;
                run_cnt <= in_count;
                gap_cnt <= '0;
                data    <= 1'b1;
            end else if (take || run_last) begin
                // Zero-length frames and finished runs both land in a fresh gap.
                state   <= StGap;
                run_cnt <= '0;
                gap_cnt <= GapInit;
                if (GapInit == 4'd1) begin
                    done        <= 1'b1;
                    in_ready    <= 1'b1;
                    frames_sent <= frames_sent + 8'd1;
                end
            end else begin
                case (state)
                    StRun: begin
                        run_cnt <= run_cnt - CW'(1);
                        data    <= 1'b1;
                    end
                    StGap: begin
                        if (gap_cnt == 4'd1) begin
                            state    <= StIdle;
                            gap_cnt  <= '0;
                            busy     <= 1'b0;
                            in_ready <= 1'b1;
                        end else begin
                            gap_cnt <= gap_cnt - 4'd1;
                            if (gap_cnt == 4'd2) begin
                                done        <= 1'b1;
                                in_ready    <= 1'b1;
                                frames_sent <= frames_sent + 8'd1;
                            end
                        end
                    end
                    default: begin
                        state    <= StIdle;
                        busy     <= 1'b0;
                        in_ready <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_run_pattern_gen.sv
// Randomized and directed bench for run_pattern_gen at GAP=1 and GAP=3 against a
// frame-position reference model.
module tb_run_pattern_gen;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       in_valid = 1'b0;
    logic [1:0] in_count = 2'd0;

    logic       rdy0, data0, busy0, done0;
    logic [7:0] fs0;
    logic       rdy1, data1, busy1, done1;
    logic [7:0] fs1;

    run_pattern_gen #(.CW(2), .GAP(1)) dut0 (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_count    (in_count),
        .in_ready    (rdy0),
        .data        (data0),
        .busy        (busy0),
        .done        (done0),
        .frames_sent (fs0)
    );

    run_pattern_gen #(.CW(2), .GAP(3)) dut1 (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_count    (in_count),
        .in_ready    (rdy1),
        .data        (data1),
        .busy        (busy1),
        .done        (done1),
        .frames_sent (fs1)
    );

    always #5 clk = ~clk;

    int gaps [2] = '{1, 3};
    int rem  [2];
    int len  [2];
    int cnt  [2];
    int frames [2];
    int xfers  [2];
    bit started [2];

    int vectors = 0;
    int errors  = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Frame seen as a window of len cycles; the first cnt positions carry ones.
    function automatic logic [11:0] model_vec(input int i);
        int   pos;
        logic d;
        pos = len[i] - rem[i];
        d   = (rem[i] > 0) && (pos < cnt[i]);
        return {d, rem[i] > 0, rem[i] == 1, started[i] && (rem[i] <= 1), 8'(frames[i])};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 2; i++) begin
            rem[i] = 0; len[i] = 0; cnt[i] = 0;
            frames[i] = 0; xfers[i] = 0; started[i] = 1'b0;
        end
    endtask

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                if (started[i] && (rem[i] <= 1) && in_valid) begin
                    cnt[i] = int'(in_count);
                    len[i] = cnt[i] + gaps[i];
                    rem[i] = len[i];
                    xfers[i]++;
                end else if (rem[i] > 0) begin
                    rem[i]--;
                end
                started[i] = 1'b1;
                if (rem[i] == 1) frames[i] = (frames[i] + 1) % 256;
            end
        end
    end

    always @(negedge clk) begin
        check_eq("gap1_outputs", {20'd0, data0, busy0, done0, rdy0, fs0}, {20'd0, model_vec(0)});
        check_eq("gap3_outputs", {20'd0, data1, busy1, done1, rdy1, fs1}, {20'd0, model_vec(1)});
    end

    task automatic drive(input bit v, input logic [1:0] c, input int n);
        in_valid = v;
        in_count = c;
        repeat (n) @(negedge clk);
    endtask

    // Called away from clock edges; returns on a negedge with reset released.
    task automatic do_reset(input int n);
        reset = 1'b0;
        model_clear();
        #1;
        check_eq("rst_data", {31'd0, data0}, 32'd0);
        check_eq("rst_busy", {31'd0, busy0 | busy1}, 32'd0);
        check_eq("rst_done", {31'd0, done0 | done1}, 32'd0);
        check_eq("rst_ready", {31'd0, rdy0 | rdy1}, 32'd0);
        check_eq("rst_frames", {24'd0, fs0}, 32'd0);
        repeat (n) @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        int g;
        model_clear();
        repeat (3) @(negedge clk);
        reset = 1'b1;

        // Single frame of two ones
        drive(1'b0, 2'd0, 2);
        drive(1'b1, 2'd2, 1);
        drive(1'b0, 2'd0, 8);
        check_eq("one_frame_count", {24'd0, fs0}, 32'd1);

        // Back-to-back 3 then 1 with valid held
        drive(1'b1, 2'd3, 1);
        drive(1'b1, 2'd1, 4);
        drive(1'b0, 2'd0, 10);
        check_eq("b2b_frame_count", {24'd0, fs0}, 32'd3);

        // Zero-length frame
        drive(1'b1, 2'd0, 1);
        drive(1'b0, 2'd0, 6);
        check_eq("zero_frame_count", {24'd0, fs0}, 32'd4);

        // Count changes during run are ignored
        drive(1'b1, 2'd1, 1);
        drive(1'b0, 2'd3, 8);
        check_eq("ignore_change_count", {24'd0, fs0}, 32'd5);

        // Reset in the second run cycle of a three-long frame
        drive(1'b1, 2'd3, 1);
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        do_reset(2);
        drive(1'b0, 2'd0, 6);
        check_eq("abort_frame_count", {24'd0, fs0}, 32'd0);

        for (int k = 0; k < 600; k++) begin
            drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1);
            if ($urandom_range(0, 79) == 0) begin
                #2;
                do_reset(2);
            end
        end
        drive(1'b0, 2'd0, 8);

        // 256 single-bit frames wrap the counter
        #2;
        do_reset(2);
        drive(1'b0, 2'd0, 1);
        in_valid = 1'b1;
        in_count = 2'd1;
        g = 0;
        while (xfers[0] < 256 && g < 3000) begin
            @(negedge clk);
            g++;
        end
        in_valid = 1'b0;
        if (g >= 3000) check_eq("wrap_timeout", g, 32'd0);
        drive(1'b0, 2'd0, 6);
        check_eq("wrap_frame_count", {24'd0, fs0}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/run_pattern_gen.md
RUN_PATTERN_GEN -- requirements
Module: run_pattern_gen

Interface
REQ-001 SHALL have parameter CW, default 2, meaning run-length field width in bits.
REQ-002 SHALL have parameter GAP, default 1, meaning zero bits emitted after each run (legal range 1..15).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  in_count holds a run length to send.
REQ-006 SHALL have port in_count  input  CW  number of consecutive 1 bits to emit (0..2^CW-1).
REQ-007 SHALL have port in_ready  output  1  block accepts in_count this cycle.
REQ-008 SHALL have port data  output  1  serial bit stream, registered.
REQ-009 SHALL have port busy  output  1  high while in RUN or GAP.
REQ-010 SHALL have port done  output  1  one-cycle pulse in last GAP cycle of each frame.
REQ-011 SHALL have port frames_sent  output  8  count of completed frames, wraps 255->0.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, GAP; registered outputs only, no combinational path from inputs to data.
REQ-013 SHALL accept a frame on a rising edge where in_valid=1 and in_ready=1 (transfer); in_count is captured into a CW-bit run counter at that edge.
REQ-014 SHALL drive in_ready=1 in IDLE and during the last GAP cycle; in_ready=0 in all other cycles.
REQ-015 SHALL, on transfer with in_count>0, enter RUN; data=1 for exactly in_count cycles starting the cycle after transfer.
REQ-016 SHALL, on transfer with in_count=0, skip RUN and enter GAP directly; data=0 throughout.
REQ-017 SHALL, after the last RUN cycle, enter GAP; data=0 for exactly GAP cycles.
REQ-018 SHALL assert done and increment frames_sent (mod 256) in the last GAP cycle.
REQ-019 SHALL, in the last GAP cycle: if transfer occurs, go to RUN (in_count>0) or restart GAP (in_count=0) with no idle cycle between frames; otherwise go to IDLE.
REQ-020 SHALL drive data=0, busy=0, done=0 in IDLE; busy=1 in RUN and GAP.
REQ-021 SHALL ignore in_valid and in_count when in_ready=0; in_count changes mid-frame do not affect the frame in progress.
REQ-022 SHALL use a CW-bit run down-counter and a 4-bit gap down-counter; no counter wraps below zero, and maximum run 2^CW-1 is emitted in full.
REQ-023 SHALL produce frame length (cycles from first data bit to done inclusive) = in_count + GAP.

Reset
REQ-024 SHALL, while reset=0, force state IDLE, data=0, busy=0, done=0, frames_sent=0, in_ready=0, counters=0, independent of clk.
REQ-025 SHALL drive in_ready=1 from the first rising clk edge after reset deasserts.
REQ-026 SHALL abort any frame in progress on reset assertion; the frame is not counted and done does not pulse.

Verification
REQ-027 SHALL cover: CW=2, GAP=1, transfer in_count=2 -> data 1,1,0; done in 3rd cycle; frames_sent=1; return to IDLE.
REQ-028 SHALL cover: in_count=3 then in_count=1 presented back-to-back, in_valid held -> data 1,1,1,0,1,0 with no idle gap; done pulses twice; frames_sent=2.
REQ-029 SHALL cover: in_count=0 -> data 0 for 1 cycle, done pulses, busy high 1 cycle, frames_sent increments.
REQ-030 SHALL cover: GAP=3, in_count=1, in_count changed to 3 during RUN -> data 1,0,0,0; change ignored; in_ready=1 only in IDLE and 4th cycle.
REQ-031 SHALL cover: reset=0 asserted during 2nd RUN cycle of in_count=3 -> data=0, busy=0 immediately; frames_sent stays 0; no done.
REQ-032 SHALL cover: 256 consecutive in_count=1 frames -> frames_sent wraps to 0 after the 256th done.
